// File: rtl/wb_stage.sv
// Writeback stage: selects the result, waits for and extracts load data,
// and drives the register-file write port; flags bad loads and timeouts.
module wb_stage #(
    parameter int N   = 32,
    parameter int RA  = 5,
    parameter int TMO = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    mem2reg,
    input  logic [2:0]    funct3,
    input  logic          reg_write,
    input  logic [RA-1:0] rd,
    input  logic [N-1:0]  ALUres,
    input  logic [N-1:0]  NPCin,
    input  logic [N-1:0]  IMMin,
    input  logic          mem_rvalid,
    input  logic [N-1:0]  mem_rdata,
    output logic          rf_we,
    output logic [RA-1:0] rf_waddr,
    output logic [N-1:0]  rf_wdata,
    output logic          err
);

    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WRITE
    } state_t;

    typedef struct packed {
        logic [2:0]    funct3;
        logic          reg_write;
        logic [RA-1:0] rd;
        logic [1:0]    off;
    } hold_t;

    state_t        state_q, state_d;
    hold_t         hold_q, hold_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] tcnt_q, tcnt_d;

    logic          accept;
    logic          is_load;
    logic          ld_bad;
    logic [N-1:0]  sel;
    logic [N-1:0]  ld_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [CW-1:0] tcnt_inc;

    assign in_ready = (state_q != WAIT_MEM);
    assign accept   = in_valid && in_ready;
    assign is_load  = (mem2reg == 2'b10);
    assign tcnt_inc = tcnt_q + CW'(1);

    always_comb begin
        sel = ALUres;
        case (mem2reg)
            2'b00:   sel = NPCin;
            2'b11:   sel = IMMin;
            default: sel = ALUres;
        endcase
    end

    // Alignment is judged from the entry's offset before any wait starts
    always_comb begin
        ld_bad = 1'b1;
        case (funct3)
            3'b000, 3'b100: ld_bad = 1'b0;
            3'b001, 3'b101: ld_bad = ALUres[0];
            3'b010:         ld_bad = (ALUres[1:0] != 2'b00);
            default:        ld_bad = 1'b1;
        endcase
    end

    assign ld_byte = mem_rdata[{hold_q.off, 3'b000} +: 8];
    assign ld_half = hold_q.off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ld_data = '0;
        case (hold_q.funct3)
            3'b000:  ld_data = N'($signed(ld_byte));
            3'b100:  ld_data = N'(ld_byte);
            3'b001:  ld_data = N'($signed(ld_half));
            3'b101:  ld_data = N'(ld_half);
            3'b010:  ld_data = N'($signed(mem_rdata[31:0]));
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    wdata_d = ld_data;
                    state_d = WRITE;
                end else if (tcnt_inc == CW'(TMO)) begin
                    err_d   = 1'b1;
                    tcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    hold_d.funct3    = funct3;
                    hold_d.reg_write = reg_write;
                    hold_d.rd        = rd;
                    hold_d.off       = ALUres[1:0];
                    if (!is_load) begin
                        wdata_d = sel;
                        state_d = WRITE;
                    end else if (ld_bad) begin
                        err_d = 1'b1;
                    end else begin
                        tcnt_d  = '0;
                        state_d = WAIT_MEM;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign rf_we    = (state_q == WRITE) && hold_q.reg_write && (hold_q.rd != '0);
    assign rf_waddr = hold_q.rd;
    assign rf_wdata = wdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a
// transaction-level model of the writeback rules.
module tb_wb_stage;

    localparam int N   = 32;
    localparam int RA  = 5;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    mem2reg = '0;
    logic [2:0]    funct3 = '0;
    logic          reg_write = 1'b0;
    logic [RA-1:0] rd = '0;
    logic [N-1:0]  ALUres = '0;
    logic [N-1:0]  NPCin = '0;
    logic [N-1:0]  IMMin = '0;
    logic          mem_rvalid = 1'b0;
    logic [N-1:0]  mem_rdata = '0;
    logic          rf_we;
    logic [RA-1:0] rf_waddr;
    logic [N-1:0]  rf_wdata;
    logic          err;

    int total = 0;
    int bad = 0;

    wb_stage #(.N(N), .RA(RA), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem2reg(mem2reg), .funct3(funct3),
        .reg_write(reg_write), .rd(rd),
        .ALUres(ALUres), .NPCin(NPCin), .IMMin(IMMin),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .err(err)
    );

    always #5 clk = ~clk;

    // Model: a pending load and the outputs expected after the next edge
    bit          m_wait;
    int          m_cnt;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    bit          m_rw;
    int          m_rd;
    bit          e_we, e_err, e_rdy;
    int          e_addr;
    logic [31:0] e_data;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit load_bad(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return off % 2 != 0;
        if (f3 == 3'd2) return off != 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3,
                                             input logic [1:0] off,
                                             input logic [31:0] w);
        int b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 128) ? b - 256 : b;
            3'd4: return b;
            3'd1: return (h >= 32768) ? h - 65536 : h;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        m_wait = 0;
        m_cnt  = 0;
    endtask

    task automatic step();
        e_we  = 0;
        e_err = 0;
        if (m_wait) begin
            if (mem_rvalid) begin
                m_wait = 0;
                e_data = load_val(m_f3, m_off, mem_rdata);
                e_we   = m_rw && m_rd != 0;
                e_addr = m_rd;
            end else begin
                m_cnt++;
                if (m_cnt == TMO) begin
                    m_wait = 0;
                    e_err  = 1;
                end
            end
        end else if (in_valid) begin
            if (mem2reg == 2'd2) begin
                if (load_bad(funct3, ALUres[1:0])) e_err = 1;
                else begin
                    m_wait = 1;
                    m_cnt  = 0;
                    m_f3   = funct3;
                    m_off  = ALUres[1:0];
                    m_rw   = reg_write;
                    m_rd   = rd;
                end
            end else begin
                e_data = (mem2reg == 0) ? NPCin : (mem2reg == 1) ? ALUres : IMMin;
                e_we   = reg_write && rd != 0;
                e_addr = rd;
            end
        end
        e_rdy = !m_wait;
        @(posedge clk);
        #1;
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("rf_we", 32'(rf_we), 32'(e_we));
        chk("err", 32'(err), 32'(e_err));
        if (e_we) begin
            chk("rf_waddr", 32'(rf_waddr), e_addr);
            chk("rf_wdata", rf_wdata, e_data);
        end
    endtask

    task automatic entry(input logic [1:0] m2r, input logic [2:0] f3,
                         input int r, input logic [31:0] alu);
        in_valid  = 1'b1;
        mem2reg   = m2r;
        funct3    = f3;
        reg_write = 1'b1;
        rd        = RA'(r);
        ALUres    = alu;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_we"}, 32'(rf_we), 0);
        chk({tag, "_waddr"}, 32'(rf_waddr), 0);
        chk({tag, "_wdata"}, rf_wdata, 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_rdy"}, 32'(in_ready), 1);
    endtask

    initial begin
        model_reset();
        #1;
        check_reset_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU entry
        entry(2'd1, 3'd0, 5, 32'h1234);
        step();
        chk("alu_wdata", rf_wdata, 32'h1234);
        idle();
        step();

        // LB then LBU at offset 3 with data two cycles later
        for (int k = 0; k < 2; k++) begin
            entry(2'd2, (k == 0) ? 3'd0 : 3'd4, 7, 32'h3);
            step();
            idle();
            step();
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h80FF_FFFF;
            step();
            chk(k == 0 ? "lb" : "lbu", rf_wdata,
                k == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
            idle();
            step();
        end

        // Misaligned LH
        entry(2'd2, 3'd1, 9, 32'h1);
        step();
        chk("lh_err", 32'(err), 1);
        idle();
        step();

        // LW timeout, then a stray rvalid
        entry(2'd2, 3'd2, 10, 32'h0);
        step();
        idle();
        for (int i = 0; i < TMO; i++) step();
        chk("tmo_err", 32'(err), 1);
        mem_rvalid = 1'b1;
        step();
        idle();

        // Back-to-back IMM writes, then rd=0
        for (int i = 1; i <= 5; i++) begin
            entry(2'd3, 3'd0, (i == 5) ? 0 : i, 32'h0);
            IMMin = 32'hA000 + 32'(i);
            step();
        end
        idle();
        step();

        // Reset during a pending load
        entry(2'd2, 3'd2, 12, 32'h0);
        step();
        idle();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        idle();
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            mem2reg   = 2'($urandom);
            funct3    = ($urandom_range(0, 3) == 0) ? 3'($urandom)
                      : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1 && funct3 != 3'd2)
                funct3 = funct3 | 3'd4;
            reg_write = ($urandom_range(0, 7) != 0);
            rd        = RA'($urandom);
            ALUres    = $urandom;
            NPCin     = $urandom;
            IMMin     = $urandom;
            mem_rvalid = ($urandom_range(0, 5) == 0);
            mem_rdata  = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter N, default 32, meaning datapath width (N >= 32, multiple of 8).
REQ-002 SHALL have parameter RA, default 5, meaning register-address width.
REQ-003 SHALL have parameter TMO, default 16, meaning maximum cycles to wait for load data (>= 1).
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  in  1  the MEM/WB entry is valid.
REQ-007 SHALL have port in_ready  out  1  the block accepts an entry this cycle.
REQ-008 SHALL have port mem2reg  in  2  source select: 00 NPC, 01 ALU, 10 MEM, 11 IMM.
REQ-009 SHALL have port funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 SHALL have port reg_write  in  1  the entry writes the register file.
REQ-011 SHALL have port rd  in  RA  destination register.
REQ-012 SHALL have ports ALUres, NPCin, IMMin  in  N each  candidate results; ALUres[1:0] is the load byte offset.
REQ-013 SHALL have port mem_rvalid  in  1  load data valid.
REQ-014 SHALL have port mem_rdata  in  N  raw aligned word from memory.
REQ-015 SHALL have port rf_we  out  1  register-file write strobe.
REQ-016 SHALL have port rf_waddr  out  RA  register-file write address.
REQ-017 SHALL have port rf_wdata  out  N  register-file write data.
REQ-018 SHALL have port err  out  1  one-cycle pulse: misaligned load, illegal funct3 or timeout.

Function
REQ-019 SHALL implement an FSM with states IDLE, WAIT_MEM and WRITE.
REQ-020 SHALL drive in_ready=1 in IDLE and WRITE, and 0 in WAIT_MEM.
REQ-021 SHALL accept an entry when in_valid and in_ready are both 1, and latch all entry inputs in a holding register.
REQ-022 SHALL, on accepting a non-load entry (mem2reg != 10), go to WRITE with rf_wdata = selected source (NPCin/ALUres/IMMin), giving 1-cycle latency.
REQ-023 SHALL, on accepting a load entry (mem2reg = 10), go to WAIT_MEM and clear the timeout counter.
REQ-024 SHALL sample mem_rvalid only in WAIT_MEM; mem_rvalid outside WAIT_MEM SHALL be ignored.
REQ-025 SHALL, in WAIT_MEM with mem_rvalid=1, extract the data per funct3 and offset, then go to WRITE.
REQ-026 SHALL extract LB/LBU from byte at offset and LH/LHU from the halfword at offset[1], sign- or zero-extended to N.
REQ-027 SHALL extract LW as mem_rdata[31:0], sign-extended to N when N > 32.
REQ-028 SHALL check loads at acceptance: LH/LHU with offset[0]=1, LW with offset != 0, or funct3 not in the list -> err pulse next cycle, state IDLE, no write, no wait.
REQ-029 SHALL, in WAIT_MEM, increment the timeout counter each cycle without mem_rvalid; on reaching TMO -> err pulse, IDLE, no write.
REQ-030 SHALL assert rf_we for exactly one cycle in WRITE when the latched reg_write=1 and rd != 0; otherwise rf_we=0.
REQ-031 SHALL hold rf_waddr and rf_wdata stable while in WRITE; their values outside WRITE are don't-care but SHALL NOT be X after reset.
REQ-032 SHALL, in WRITE with a new entry accepted, go directly to WRITE (non-load) or WAIT_MEM (load), sustaining one write per cycle for back-to-back non-loads.
REQ-033 SHALL return from WRITE to IDLE when no entry is accepted.

Reset
REQ-034 SHALL, on rst_n=0 at any time, go immediately to IDLE and drive rf_we=0, rf_waddr=0, rf_wdata=0, err=0, in_ready=1 and timeout counter=0.
REQ-035 SHALL discard a pending load on reset mid-WAIT_MEM; a late mem_rvalid after reset SHALL cause no write.

Verification
REQ-036 SHALL cover: ALU entry rd=5, ALUres=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234.
REQ-037 SHALL cover: LB, offset 3, mem_rdata=0x80FF_FFFF, rvalid 2 cycles later -> rf_wdata=0xFFFF_FF80 one cycle after rvalid; LBU -> 0x0000_0080.
REQ-038 SHALL cover: LH, offset 1 -> err=1 for one cycle, rf_we stays 0, in_ready=1.
REQ-039 SHALL cover: LW with no rvalid for TMO=16 cycles -> err pulse on cycle 16, return to IDLE, a later rvalid is ignored.
REQ-040 SHALL cover: four back-to-back IMM entries, rd=1..4 -> four consecutive rf_we cycles; also an entry with rd=0 -> rf_we=0.
REQ-041 SHALL cover: rst_n low during WAIT_MEM, then rvalid -> no write, all outputs at reset values.
